fir_mac_engine: RTL and testbench



---
 rtl/fir_mac_engine.sv | 158 +++++++++++++++
 tb/tb_fir_mac_engine.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_engine.sv
// Multi-channel FIR engine: per-channel circular history, external coefficient ROM, round-half-up and saturate.
// Optional build macro FIR_SAT_FLAG_EN adds a sticky per-channel saturation flag (sat_flag) with clear (sat_clr).
module fir_mac_engine #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int TAPS   = 512,
    parameter int PTR    = 9,
    parameter int CH     = 2,
    parameter int ACC_W  = 41,
    parameter int OUT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rstb,
    input  logic [CH*DATA_W-1:0]  fir_in,
    input  logic                  fir_in_rts,
    output logic                  fir_in_rtr,
    output logic [CH*OUT_W-1:0]   fir_out,
    output logic                  fir_out_rts,
    input  logic                  fir_out_rtr,
    output logic                  coef_re,
    output logic [PTR-1:0]        coef_rdptr,
    input  logic [COEF_W-1:0]     coef_rddata,
    output logic                  busy
`ifdef FIR_SAT_FLAG_EN
    ,
    output logic [CH-1:0]         sat_flag,
    input  logic                  sat_clr
`endif
);

    typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_MAC, S_DRAIN, S_ROUND, S_OUTPUT} state_t;

    localparam logic signed [ACC_W-1:0] RND     = ACC_W'(1 << (COEF_W - 2));
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    state_t state, next_state;

    logic [PTR-1:0]            clr_cnt, wr_ptr, base, hist_raddr, issue_k;
    logic                      accept, out_hs, last_issue;
    logic                      in_rtr_d, out_rts_d, coef_re_d, busy_d;
    logic                      pair_valid, pair_first;
    logic [DATA_W-1:0]         hist [CH][TAPS];
    logic signed [DATA_W-1:0]  hist_q [CH];
    logic signed [ACC_W-1:0]   acc [CH];
    logic signed [ACC_W-1:0]   prod [CH];
    logic signed [ACC_W-1:0]   rounded [CH];
    logic [OUT_W-1:0]          y [CH];

    // A transfer happens on any edge where the sender's rts and the receiver's rtr are both high;
    // rts/data stay stable until then, and rtr never depends combinationally on rts.
    assign accept     = fir_in_rts && fir_in_rtr;
    assign out_hs     = fir_out_rts && fir_out_rtr;
    assign last_issue = coef_re && (coef_rdptr == PTR'(TAPS - 1));
    assign issue_k    = coef_re ? coef_rdptr + 1'b1 : '0;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) state <= S_CLEAR;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_CLEAR:  if (clr_cnt == PTR'(TAPS - 1)) next_state = S_IDLE;
            S_IDLE:   if (accept) next_state = S_MAC;
            S_MAC:    if (last_issue) next_state = S_DRAIN;
            S_DRAIN:  next_state = S_ROUND;
            S_ROUND:  next_state = S_OUTPUT;
            S_OUTPUT: if (out_hs) next_state = S_IDLE;
            default:  next_state = S_CLEAR;
        endcase
    end

    always_comb begin
        in_rtr_d  = ((state == S_IDLE) && !accept) || ((state == S_OUTPUT) && out_hs);
        out_rts_d = (state == S_ROUND) || ((state == S_OUTPUT) && !out_hs);
        coef_re_d = (state == S_MAC) && !last_issue;
        busy_d    = (next_state != S_IDLE);
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            fir_in_rtr  <= 1'b0;
            fir_out_rts <= 1'b0;
            coef_re     <= 1'b0;
            coef_rdptr  <= '0;
            busy        <= 1'b0;
        end else begin
            fir_in_rtr  <= in_rtr_d;
            fir_out_rts <= out_rts_d;
            coef_re     <= coef_re_d;
            busy        <= busy_d;
            if (coef_re_d) coef_rdptr <= issue_k;
        end
    end

    // History RAM: read data lands one edge after the address, alongside coef_rddata.
    always_ff @(posedge clk) begin
        for (int c = 0; c < CH; c++) begin
            if (state == S_CLEAR) hist[c][clr_cnt] <= '0;
            else if (accept)      hist[c][wr_ptr] <= fir_in[c*DATA_W +: DATA_W];
            hist_q[c] <= hist[c][hist_raddr];
        end
    end

    always_comb begin
        for (int c = 0; c < CH; c++) begin
            prod[c]    = ACC_W'(hist_q[c]) * ACC_W'($signed(coef_rddata));
            rounded[c] = (acc[c] + RND) >>> (COEF_W - 1);
            if (rounded[c] > SAT_MAX)      y[c] = SAT_MAX[OUT_W-1:0];
            else if (rounded[c] < SAT_MIN) y[c] = SAT_MIN[OUT_W-1:0];
            else                           y[c] = rounded[c][OUT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            clr_cnt    <= '0;
            wr_ptr     <= '0;
            base       <= '0;
            hist_raddr <= '0;
            pair_valid <= 1'b0;
            pair_first <= 1'b0;
            fir_out    <= '0;
            for (int c = 0; c < CH; c++) acc[c] <= '0;
        end else begin
            if (state == S_CLEAR) clr_cnt <= clr_cnt + 1'b1;
            if (accept) begin
                base   <= wr_ptr;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (coef_re_d) hist_raddr <= base - issue_k;
            pair_valid <= coef_re;
            pair_first <= coef_re && (coef_rdptr == '0);
            // The k=0 product loads the accumulator, so no clear cycle is needed between samples.
            for (int c = 0; c < CH; c++) begin
                if (pair_valid) acc[c] <= pair_first ? prod[c] : acc[c] + prod[c];
                if (state == S_ROUND) fir_out[c*OUT_W +: OUT_W] <= y[c];
            end
        end
    end

`ifdef FIR_SAT_FLAG_EN
    logic [CH-1:0] sat_vec;

    always_comb begin
        sat_vec = '0;
        for (int c = 0; c < CH; c++) sat_vec[c] = (rounded[c] > SAT_MAX) || (rounded[c] < SAT_MIN);
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) sat_flag <= '0;
        else       sat_flag <= (sat_clr ? '0 : sat_flag) | ((state == S_ROUND) ? sat_vec : '0);
    end
`endif

endmodule

// File: tb/tb_fir_mac_engine.sv
// Directed bench for fir_mac_engine at TAPS=8: reset/clear timing, impulse, saturation, rounding,
// backpressure and mid-MAC reset, with a registered coefficient ROM model.
module tb_fir_mac_engine;

    localparam int TAPS = 8;
    localparam int PTR  = 3;

    logic        clk;
    logic        rstb;
    logic [31:0] fir_in;
    logic        fir_in_rts;
    logic        fir_in_rtr;
    logic [31:0] fir_out;
    logic        fir_out_rts;
    logic        fir_out_rtr;
    logic        coef_re;
    logic [PTR-1:0] coef_rdptr;
    logic [15:0] coef_rddata;
    logic        busy;
`ifdef FIR_SAT_FLAG_EN
    logic [1:0]  sat_flag;
    logic        sat_clr;
`endif

    logic [15:0] coef_tab [TAPS];
    int n_tests = 0;
    int n_fail  = 0;

    fir_mac_engine #(
        .DATA_W(16), .COEF_W(16), .TAPS(TAPS), .PTR(PTR), .CH(2), .ACC_W(41), .OUT_W(16)
    ) dut (
        .clk         (clk),
        .rstb        (rstb),
        .fir_in      (fir_in),
        .fir_in_rts  (fir_in_rts),
        .fir_in_rtr  (fir_in_rtr),
        .fir_out     (fir_out),
        .fir_out_rts (fir_out_rts),
        .fir_out_rtr (fir_out_rtr),
        .coef_re     (coef_re),
        .coef_rdptr  (coef_rdptr),
        .coef_rddata (coef_rddata),
        .busy        (busy)
`ifdef FIR_SAT_FLAG_EN
        ,
        .sat_flag    (sat_flag),
        .sat_clr     (sat_clr)
`endif
    );

    // clock / reset-independent infrastructure
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) coef_rddata <= coef_re ? coef_tab[coef_rdptr] : 16'h0000;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic set_coef_all(input logic [15:0] v);
        for (int k = 0; k < TAPS; k++) coef_tab[k] = v;
    endtask

    task automatic do_reset(input string tag);
        int edges;
        fir_in_rts  = 1'b0;
        fir_out_rtr = 1'b0;
        @(negedge clk);
        rstb = 1'b0;
        #1;
        check({tag, " rst fir_out"}, fir_out, 32'h0);
        check({tag, " rst out_rts"}, fir_out_rts, 1'b0);
        check({tag, " rst in_rtr"}, fir_in_rtr, 1'b0);
        check({tag, " rst coef_re"}, coef_re, 1'b0);
        check({tag, " rst busy"}, busy, 1'b0);
        repeat (2) @(negedge clk);
        rstb = 1'b1;
        edges = 0;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk);
            #1;
            if (fir_in_rtr) begin
                edges = e;
                break;
            end
        end
        check({tag, " clear edges"}, edges, TAPS + 1);
    endtask

    task automatic accept(input logic [15:0] s0, input logic [15:0] s1, input string tag);
        logic ok;
        ok = 1'b0;
        fir_in = {s1, s0};
        fir_in_rts = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (fir_in_rtr) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, " accepted"}, ok, 1'b1);
        @(posedge clk);
        #1;
        fir_in_rts = 1'b0;
        fir_in = 32'h0;
        check({tag, " busy"}, busy, 1'b1);
    endtask

    task automatic collect(input logic [15:0] e0, input logic [15:0] e1, input int hold, input string tag);
        int lat;
        logic rtr_seen, moved;
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (fir_out_rts) begin
                lat = i;
                break;
            end
        end
        check({tag, " latency"}, lat, TAPS + 3);
        check({tag, " data"}, fir_out, {e1, e0});
        if (hold > 0) begin
            rtr_seen = 1'b0;
            moved = 1'b0;
            fir_in_rts = 1'b1;
            fir_in = 32'h7FFF_7FFF;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk);
                #1;
                if (fir_in_rtr) rtr_seen = 1'b1;
                if (fir_out !== {e1, e0} || fir_out_rts !== 1'b1) moved = 1'b1;
            end
            check({tag, " bp in_rtr"}, rtr_seen, 1'b0);
            check({tag, " bp stable"}, moved, 1'b0);
            fir_in_rts = 1'b0;
            fir_in = 32'h0;
        end
        fir_out_rtr = 1'b1;
        @(posedge clk);
        #1;
        fir_out_rtr = 1'b0;
        check({tag, " rts drop"}, fir_out_rts, 1'b0);
        check({tag, " out held"}, fir_out, {e1, e0});
        check({tag, " rtr back"}, fir_in_rtr, 1'b1);
        check({tag, " idle"}, busy, 1'b0);
    endtask

    task automatic run_impulse(input string tag, input int bp_at);
        logic [15:0] e0;
        for (int k = 0; k < TAPS; k++) coef_tab[k] = 16'(16'h0800 * (k + 1));
        for (int n = 0; n <= TAPS; n++) begin
            e0 = (n < TAPS) ? 16'(16'h0400 * (n + 1)) : 16'h0000;
            accept((n == 0) ? 16'h4000 : 16'h0000, 16'h0000, $sformatf("%s%0d", tag, n));
            collect(e0, 16'h0000, (n == bp_at) ? 50 : 0, $sformatf("%s%0d", tag, n));
        end
    endtask

    initial begin
        logic [15:0] e;
        rstb = 1'b0;
        fir_in = 32'h0;
        fir_in_rts = 1'b0;
        fir_out_rtr = 1'b0;
`ifdef FIR_SAT_FLAG_EN
        sat_clr = 1'b0;
`endif
        set_coef_all(16'h7FFF);

        do_reset("por");
        accept(16'h0000, 16'h0000, "zero");
        collect(16'h0000, 16'h0000, 0, "zero");

        run_impulse("imp", 3);

`ifdef FIR_SAT_FLAG_EN
        check("satflag before", sat_flag, 2'b00);
`endif
        set_coef_all(16'h7FFF);
        for (int i = 1; i <= TAPS; i++) begin
            e = (i == 1) ? 16'h7FFE : 16'h7FFF;
            accept(16'h7FFF, 16'h7FFF, $sformatf("satp%0d", i));
            collect(e, e, 0, $sformatf("satp%0d", i));
        end
`ifdef FIR_SAT_FLAG_EN
        check("satflag set", sat_flag, 2'b11);
        sat_clr = 1'b1;
        @(posedge clk);
        #1;
        sat_clr = 1'b0;
        check("satflag clr", sat_flag, 2'b00);
`endif
        for (int k = 1; k <= TAPS; k++) begin
            e = (k <= 3) ? 16'h7FFF : (k == 4) ? 16'hFFFC : 16'h8000;
            accept(16'h8000, 16'h8000, $sformatf("satn%0d", k));
            collect(e, e, 0, $sformatf("satn%0d", k));
        end

        set_coef_all(16'h0000);
        coef_tab[0] = 16'h4000;
        accept(16'h0001, 16'hFFFF, "rnd0");
        collect(16'h0001, 16'h0000, 0, "rnd0");
        accept(16'h0003, 16'h0001, "rnd1");
        collect(16'h0002, 16'h0001, 0, "rnd1");
        accept(16'hFFFF, 16'h0003, "rnd2");
        collect(16'h0000, 16'h0002, 0, "rnd2");

        set_coef_all(16'h7FFF);
        accept(16'h1234, 16'h1234, "midmac");
        repeat (4) @(posedge clk);
        #3;
        check("midmac coef_re", coef_re, 1'b1);
        rstb = 1'b0;
        #1;
        check("midmac fir_out", fir_out, 32'h0);
        check("midmac out_rts", fir_out_rts, 1'b0);
        check("midmac coef_re off", coef_re, 1'b0);
        do_reset("mid");
        run_impulse("reimp", -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
